// File: rtl/imm_pkg.sv
// -----------------------------------------------------------------------------
// imm_pkg -- shared definitions for the immediate compressor.
//   IMM_W    : width of the full immediate presented to the compressor
//   FIELD_W  : width of the compressed field
//   SHORT_W  : width of the short (5-bit) immediate formats
//   imm_fmt_e: compressed format selected by ExtOp/ExtPlace
//   decode_fmt(): ExtOp/ExtPlace -> imm_fmt_e
// -----------------------------------------------------------------------------
package imm_pkg;

  localparam int IMM_W   = 16;
  localparam int FIELD_W = 8;
  localparam int SHORT_W = 5;

  typedef enum logic [1:0] {
    IMM5U = 2'd0,  // 5-bit field, zero-extended
    IMM5S = 2'd1,  // 5-bit field, sign-extended
    IMM8U = 2'd2   // 8-bit field, zero-extended
  } imm_fmt_e;

  // ExtPlace selects the 8-bit format and overrides ExtOp.
  function automatic imm_fmt_e decode_fmt(input logic ext_op, input logic ext_place);
    imm_fmt_e fmt;
    if (ext_place == 1'b1) begin
      fmt = IMM8U;
    end else if (ext_op == 1'b1) begin
      fmt = IMM5S;
    end else begin
      fmt = IMM5U;
    end
    return fmt;
  endfunction

endpackage

// File: rtl/imm_fit_check.sv
// -----------------------------------------------------------------------------
// imm_fit_check -- combinational fit test and field extraction.
// Ports:
//   value_i [IMM_W]   : full-width immediate
//   fmt_i             : target compressed format
//   field_o [FIELD_W] : compressed field (produced whether or not it fits)
//   fits_o            : 1 when re-extending field_o reproduces value_i
// -----------------------------------------------------------------------------
module imm_fit_check
  import imm_pkg::*;
(
  input  logic [IMM_W-1:0]   value_i,
  input  imm_fmt_e           fmt_i,
  output logic [FIELD_W-1:0] field_o,
  output logic               fits_o
);

  // Sign-extended 5-bit form: bits [15:4] must be a pure copy of the sign bit.
  logic [IMM_W-SHORT_W:0] sign_span_s;
  assign sign_span_s = value_i[IMM_W-1:SHORT_W-1];

  // Select field and evaluate the fit rule for the requested format.
  always_comb begin
    field_o = {FIELD_W{1'b0}};
    fits_o  = 1'b0;
    case (fmt_i)
      IMM8U: begin
        field_o = value_i[FIELD_W-1:0];
        fits_o  = (value_i[IMM_W-1:FIELD_W] == {(IMM_W-FIELD_W){1'b0}});
      end
      IMM5U: begin
        field_o = {{(FIELD_W-SHORT_W){1'b0}}, value_i[SHORT_W-1:0]};
        fits_o  = (value_i[IMM_W-1:SHORT_W] == {(IMM_W-SHORT_W){1'b0}});
      end
      IMM5S: begin
        field_o = {{(FIELD_W-SHORT_W){1'b0}}, value_i[SHORT_W-1:0]};
        fits_o  = (&sign_span_s) | (~|sign_span_s);
      end
      default: begin
        field_o = {FIELD_W{1'b0}};
        fits_o  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/imm_compressor.sv
// -----------------------------------------------------------------------------
// imm_compressor -- two-stage valid/ready pipeline that compresses a 16-bit
// immediate into an 8-bit field (inverse of the datapath immediate extender).
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_ready, value[16], ExtOp, ExtPlace : request side
//   out_valid/out_ready, field[8], fits           : result side
//   stat_clr, ovf_count[CNT_W]                    : overflow statistics
// Build option: define IMM_COMPRESSOR_STATS_EN to include the overflow
// counter; otherwise ovf_count is tied to zero and stat_clr is ignored.
// -----------------------------------------------------------------------------
module imm_compressor
  import imm_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IMM_W-1:0]   value,
  input  logic               ExtOp,
  input  logic               ExtPlace,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIELD_W-1:0] field,
  output logic               fits,
  input  logic               stat_clr,
  output logic [CNT_W-1:0]   ovf_count
);

  logic               s1_valid_q, s1_valid_d;
  logic [IMM_W-1:0]   s1_value_q, s1_value_d;
  imm_fmt_e           s1_fmt_q, s1_fmt_d;
  logic               s2_valid_q, s2_valid_d;
  logic [FIELD_W-1:0] field_q, field_d;
  logic               fits_q, fits_d;

  logic               s2_ready_s;
  logic               s1_adv_s;
  logic               in_xfer_s;
  logic               out_xfer_s;
  logic [FIELD_W-1:0] chk_field_s;
  logic               chk_fits_s;

  // Ready chain uses only registered valids and out_ready.
  assign s2_ready_s = ~s2_valid_q | out_ready;
  assign s1_adv_s   = s1_valid_q & s2_ready_s;
  assign in_ready   = ~s1_valid_q | s1_adv_s;
  assign in_xfer_s  = in_valid & in_ready;
  assign out_xfer_s = s2_valid_q & out_ready;

  imm_fit_check u_fit (
    .value_i (s1_value_q),
    .fmt_i   (s1_fmt_q),
    .field_o (chk_field_s),
    .fits_o  (chk_fits_s)
  );

  // Next-state for both pipeline stages.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_value_d = s1_value_q;
    s1_fmt_d   = s1_fmt_q;
    s2_valid_d = s2_valid_q;
    field_d    = field_q;
    fits_d     = fits_q;
    if (in_xfer_s) begin
      s1_valid_d = 1'b1;
      s1_value_d = value;
      s1_fmt_d   = decode_fmt(ExtOp, ExtPlace);
    end else if (s1_adv_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    // S2 refills when empty or draining; a bubble from S1 just clears valid.
    if (s2_ready_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        field_d = chk_field_s;
        fits_d  = chk_fits_s;
      end else begin
        field_d = field_q;
        fits_d  = fits_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  // Pipeline state registers; reset drops any in-flight request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_value_q <= {IMM_W{1'b0}};
      s1_fmt_q   <= IMM5U;
      s2_valid_q <= 1'b0;
      field_q    <= {FIELD_W{1'b0}};
      fits_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_value_q <= s1_value_d;
      s1_fmt_q   <= s1_fmt_d;
      s2_valid_q <= s2_valid_d;
      field_q    <= field_d;
      fits_q     <= fits_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign field     = field_q;
  assign fits      = fits_q;

`ifdef IMM_COMPRESSOR_STATS_EN
  logic [CNT_W-1:0] ovf_q, ovf_d;

  // Saturating count of non-fitting output transfers; clear wins.
  always_comb begin
    ovf_d = ovf_q;
    if (stat_clr) begin
      ovf_d = {CNT_W{1'b0}};
    end else if (out_xfer_s && !fits_q && !(&ovf_q)) begin
      ovf_d = ovf_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_q <= {CNT_W{1'b0}};
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf_count = ovf_q;
`else
  logic stat_unused_s;
  assign stat_unused_s = stat_clr | out_xfer_s;
  assign ovf_count     = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_imm_compressor.sv
// -----------------------------------------------------------------------------
// tb_imm_compressor -- directed self-checking bench for imm_compressor.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Counter checks depend on IMM_COMPRESSOR_STATS_EN.
// -----------------------------------------------------------------------------
module tb_imm_compressor;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] value;
  logic        ExtOp;
  logic        ExtPlace;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  field;
  logic        fits;
  logic        stat_clr;
  logic [7:0]  ovf_count;

  int n_total = 0;
  int n_bad   = 0;

  imm_compressor #(.CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .value     (value),
    .ExtOp     (ExtOp),
    .ExtPlace  (ExtPlace),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .field     (field),
    .fits      (fits),
    .stat_clr  (stat_clr),
    .ovf_count (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference immediate extender (the operation the compressor inverts).
  function automatic logic [15:0] extend(input logic [7:0] f, input logic op, input logic pl);
    if (pl) return {8'h00, f};
    else if (op) return {{11{f[4]}}, f[4:0]};
    else return {11'h000, f[4:0]};
  endfunction

  // Single request through an empty pipeline; result consumed on arrival.
  task automatic run_one(input string tag, input logic [15:0] v, input logic op,
                         input logic pl, input logic [7:0] ef, input logic efits);
    logic got;
    @(negedge clk);
    value = v; ExtOp = op; ExtPlace = pl; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (out_valid) got = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_vld"}, got, 1'b1);
    chk({tag, "_field"}, field, ef);
    chk({tag, "_fits"}, fits, efits);
    @(posedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [7:0]  vals [6];
  logic [7:0]  gotq [$];
  logic        acc;
  logic        seen;
  int          idx;
  logic [15:0] rv;
  logic        rop, rpl;
  logic [7:0]  ef;
  logic        efits;

  initial begin
    reset = 1'b1; in_valid = 1'b0; value = 16'h0000; ExtOp = 1'b0; ExtPlace = 1'b0;
    out_ready = 1'b0; stat_clr = 1'b0;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    vals[3] = 8'h44; vals[4] = 8'h55; vals[5] = 8'h66;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_field", field, 8'h00);
    chk("rst_fits", fits, 1'b0);
    chk("rst_ovf", ovf_count, 8'h00);
    reset = 1'b0;

    // Directed formats
    run_one("s5_pos",  16'h000F, 1'b1, 1'b0, 8'h0F, 1'b1);
    run_one("s5_neg",  16'hFFF0, 1'b1, 1'b0, 8'h10, 1'b1);
    run_one("s5_ovf",  16'h0010, 1'b1, 1'b0, 8'h10, 1'b0);
    run_one("u5_max",  16'h001F, 1'b0, 1'b0, 8'h1F, 1'b1);
    run_one("u5_ovf",  16'h0020, 1'b0, 1'b0, 8'h00, 1'b0);
    run_one("u8_max",  16'h00FF, 1'b0, 1'b1, 8'hFF, 1'b1);
    run_one("u8_ovf",  16'h0100, 1'b0, 1'b1, 8'h00, 1'b0);
    run_one("s5_min",  16'hFFEF, 1'b1, 1'b0, 8'h0F, 1'b0);
    run_one("u8_xop",  16'h0080, 1'b1, 1'b1, 8'h80, 1'b1);

    // Back-to-back stream: results two cycles after presentation, no gaps
    for (int n = 0; n <= 12; n++) begin
      @(negedge clk);
      chk($sformatf("b2b_vld%0d", n), out_valid, (n >= 2 && n < 12));
      if (n >= 2 && n < 12) chk($sformatf("b2b_f%0d", n), field, 8'((n - 2) * 3));
      out_ready = 1'b1;
      in_valid  = (n < 10);
      ExtPlace  = 1'b1; ExtOp = 1'b0;
      value     = 16'(n * 3);
      #1;
      if (n < 10) chk($sformatf("b2b_rdy%0d", n), in_ready, 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;

    // Backpressure: two accepts then stall with a stable output
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; ExtPlace = 1'b1; value = {8'h00, vals[idx]};
      #1;
      acc = in_ready;
      if (c >= 2) begin
        chk($sformatf("stall_rdy%0d", c), in_ready, 1'b0);
        chk($sformatf("stall_vld%0d", c), out_valid, 1'b1);
        chk($sformatf("stall_f%0d", c), field, vals[0]);
      end
      @(posedge clk);
      if (acc) idx++;
    end
    chk("stall_accepts", idx, 2);
    for (int c = 0; c < 20 && gotq.size() < 6; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (idx < 6);
      value     = (idx < 6) ? {8'h00, vals[idx]} : 16'h0000;
      #1;
      if (c == 0) chk("release_rdy", in_ready, 1'b1);
      acc = in_valid & in_ready;
      if (out_valid) gotq.push_back(field);
      @(posedge clk);
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("release_count", gotq.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < gotq.size()) chk($sformatf("release_ord%0d", i), gotq[i], vals[i]);
    end

    // Reset with both stages full
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; ExtPlace = 1'b1; value = 16'h00AA;
    @(posedge clk);
    @(negedge clk);
    value = 16'h00BB;
    @(posedge clk);
    #2;
    chk("full_before_rst", out_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("async_rst_vld", out_valid, 1'b0);
    chk("async_rst_rdy", in_ready, 1'b1);
    chk("async_rst_field", field, 8'h00);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("post_rst_silent", seen, 1'b0);

    // Random round trip against the reference extender
    for (int k = 0; k < 40; k++) begin
      rop = 1'($urandom_range(0, 1));
      rpl = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: rv = 16'($urandom_range(0, 65535));
        1: rv = {{11{1'($urandom_range(0, 1))}}, 5'($urandom_range(0, 31))};
        default: rv = {8'h00, 8'($urandom_range(0, 255))};
      endcase
      ef    = rpl ? rv[7:0] : {3'b000, rv[4:0]};
      efits = (extend(ef, rop, rpl) == rv);
      run_one($sformatf("rt%0d", k), rv, rop, rpl, ef, efits);
      if (fits) chk($sformatf("rt%0d_ext", k), extend(field, rop, rpl), rv);
    end

`ifdef IMM_COMPRESSOR_STATS_EN
    pulse_reset();
    chk("stat_start", ovf_count, 8'd0);
    run_one("stat_a", 16'h0100, 1'b0, 1'b1, 8'h00, 1'b0);
    run_one("stat_b", 16'h0001, 1'b0, 1'b1, 8'h01, 1'b1);
    run_one("stat_c", 16'h0020, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("stat_two", ovf_count, 8'd2);
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1; ExtPlace = 1'b1; value = 16'h0100;
    repeat (298) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("stat_sat", ovf_count, 8'd255);
    @(negedge clk);
    in_valid = 1'b1; value = 16'h0100;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("clr_vld", out_valid, 1'b1);
    stat_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stat_clr = 1'b0;
    chk("clr_prio", ovf_count, 8'd0);
`else
    run_one("nostat_a", 16'h0100, 1'b0, 1'b1, 8'h00, 1'b0);
    run_one("nostat_b", 16'h0040, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("nostat_zero", ovf_count, 8'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
